oled_frame_streamer: RTL and testbench

//  Display-side end of the pixel_index -> oled_data interface. Walks pixel_index 0..6143 each frame.

---
 rtl/oled_pkg.sv | 24 ++
 rtl/oled_frame_streamer_if.sv | 23 ++
 rtl/oled_spi_shifter.sv | 55 +++++
 rtl/oled_frame_streamer.sv | 156 +++++++++++++++
 tb/tb_oled_frame_streamer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - SSD1331 geometry, command codes and window preamble shared by image sources
package oled_pkg;

  localparam int OLED_W    = 96;
  localparam int OLED_H    = 64;
  localparam int OLED_NPIX = OLED_W * OLED_H;

  localparam logic [7:0] OLED_CMD_SETCOL = 8'h15;
  localparam logic [7:0] OLED_CMD_SETROW = 8'h75;

  // Full-panel column then row window; resent every frame so a lost frame self-recovers
  localparam logic [7:0] OLED_PREAMBLE [0:5] = '{
    OLED_CMD_SETCOL, 8'h00, 8'(OLED_W - 1),
    OLED_CMD_SETROW, 8'h00, 8'(OLED_H - 1)
  };

  typedef enum logic [1:0] {
    ST_GAP,
    ST_IDLE,
    ST_CMD,
    ST_PIXEL
  } oled_state_e;

endpackage

// File: rtl/oled_frame_streamer_if.sv
// rtl/oled_frame_streamer_if.sv - pixel fetch and 4-wire SPI signals of the frame streamer
interface oled_frame_streamer_if;

  logic        en;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic        frame_begin;
  logic        oled_cs;
  logic        oled_sclk;
  logic        oled_sdin;
  logic        oled_dc;

  modport master (
    input  en, pixel_data,
    output pixel_index, frame_begin, oled_cs, oled_sclk, oled_sdin, oled_dc
  );

  modport slave (
    output en, pixel_data,
    input  pixel_index, frame_begin, oled_cs, oled_sclk, oled_sdin, oled_dc
  );

endinterface

// File: rtl/oled_spi_shifter.sv
// rtl/oled_spi_shifter.sv - 8/16-bit MSB-first SPI shifter, two clk cycles per bit
module oled_spi_shifter (
  input  logic        clk6p25m,
  input  logic        rst_n,
  input  logic        load,
  input  logic        len16,
  input  logic [15:0] din,
  output logic        sclk,
  output logic        sdin,
  output logic        done
);

  logic [15:0] shreg;
  logic [4:0]  cyc;
  logic [4:0]  last_cyc;
  logic        busy;

  // Last cycle of the word is the high phase of its final bit; a reload there keeps bytes back-to-back
  assign done = busy && (cyc == last_cyc);

  // Even cycles drive sclk low with the new bit, odd cycles raise sclk for the panel to sample
  always_ff @(posedge clk6p25m) begin
    if (!rst_n) begin
      shreg    <= 16'h0000;
      cyc      <= 5'd0;
      last_cyc <= 5'd0;
      busy     <= 1'b0;
      sclk     <= 1'b1;
      sdin     <= 1'b0;
    end else if (load) begin
      shreg    <= din;
      cyc      <= 5'd0;
      last_cyc <= len16 ? 5'd31 : 5'd15;
      busy     <= 1'b1;
      sclk     <= 1'b0;
      sdin     <= din[15];
    end else if (busy) begin
      if (cyc == last_cyc) begin
        busy <= 1'b0;
        sclk <= 1'b1;
        sdin <= 1'b0;
      end else begin
        cyc <= cyc + 5'd1;
        if (!cyc[0]) begin
          sclk <= 1'b1;
        end else begin
          sclk  <= 1'b0;
          sdin  <= shreg[14];
          shreg <= {shreg[14:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/oled_frame_streamer.sv
// rtl/oled_frame_streamer.sv - walks pixel_index each frame and streams RGB565 words to the SSD1331
module oled_frame_streamer
  import oled_pkg::*;
#(
  parameter int PIX_LAT    = 1,
  parameter int GAP_CYCLES = 64,
  parameter int NPIX       = OLED_NPIX
) (
  input  logic                  clk6p25m,
  input  logic                  rst_n,
  oled_frame_streamer_if.master io
);

  if (PIX_LAT < 1 || PIX_LAT > 16 || GAP_CYCLES < 2) begin : g_param_range
    $error("oled_frame_streamer: PIX_LAT must be 1..16 and GAP_CYCLES >= 2");
  end

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [12:0] LAST_PIX = 13'(NPIX - 1);
  localparam logic [2:0]  CMD_LAST = 3'd5;

  oled_state_e state;
  logic [15:0] gap_cnt;
  logic [2:0]  cmd_idx;
  logic [12:0] pix_cnt;
  logic [12:0] pixel_index;
  logic        frame_begin;
  logic        cs;
  logic        dc;

  logic        start;
  logic        sh_load;
  logic        sh_len16;
  logic [15:0] sh_din;
  logic        sh_done;
  logic        sh_sclk;
  logic        sh_sdin;

  // A frame may only start at the GAP terminal count or from IDLE, and only while en is high
  assign start = io.en && (((state == ST_GAP) && (gap_cnt == GAP_LAST)) || (state == ST_IDLE));

  // Choose the next word for the shifter; pixel_data only ever lands in the shift register
  always_comb begin
    sh_load  = 1'b0;
    sh_len16 = 1'b0;
    sh_din   = 16'h0000;
    case (state)
      ST_GAP, ST_IDLE: begin
        if (start) begin
          sh_load = 1'b1;
          sh_din  = {OLED_PREAMBLE[0], 8'h00};
        end
      end
      ST_CMD: begin
        if (sh_done) begin
          sh_load = 1'b1;
          if (cmd_idx == CMD_LAST) begin
            sh_len16 = 1'b1;
            sh_din   = io.pixel_data;
          end else begin
            sh_din = {OLED_PREAMBLE[cmd_idx + 3'd1], 8'h00};
          end
        end
      end
      ST_PIXEL: begin
        if (sh_done && (pix_cnt != LAST_PIX)) begin
          sh_load  = 1'b1;
          sh_len16 = 1'b1;
          sh_din   = io.pixel_data;
        end
      end
      default: ;
    endcase
  end

  // Frame sequencer: gap count, preamble, pixel walk with one-pixel index prefetch, cs/dc
  always_ff @(posedge clk6p25m) begin
    if (!rst_n) begin
      state       <= ST_GAP;
      gap_cnt     <= 16'd0;
      cmd_idx     <= 3'd0;
      pix_cnt     <= 13'd0;
      pixel_index <= 13'd0;
      frame_begin <= 1'b0;
      cs          <= 1'b1;
      dc          <= 1'b0;
    end else begin
      frame_begin <= 1'b0;
      case (state)
        ST_GAP, ST_IDLE: begin
          if ((state == ST_GAP) && (gap_cnt != GAP_LAST)) begin
            gap_cnt <= gap_cnt + 16'd1;
          end else begin
            gap_cnt <= 16'd0;
          end
          if (start) begin
            state       <= ST_CMD;
            cmd_idx     <= 3'd0;
            cs          <= 1'b0;
            dc          <= 1'b0;
            frame_begin <= 1'b1;
          end else if (state == ST_GAP && gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end
        end
        ST_CMD: begin
          if (sh_done) begin
            if (cmd_idx == CMD_LAST) begin
              state       <= ST_PIXEL;
              dc          <= 1'b1;
              pix_cnt     <= 13'd0;
              pixel_index <= 13'd1;
            end else begin
              cmd_idx <= cmd_idx + 3'd1;
            end
          end
        end
        ST_PIXEL: begin
          if (sh_done) begin
            if (pix_cnt == LAST_PIX) begin
              state       <= ST_GAP;
              cs          <= 1'b1;
              gap_cnt     <= 16'd0;
              pixel_index <= 13'd0;
            end else begin
              pix_cnt <= pix_cnt + 13'd1;
              if ((pix_cnt + 13'd1) != LAST_PIX) begin
                pixel_index <= pix_cnt + 13'd2;
              end
            end
          end
        end
        default: state <= ST_GAP;
      endcase
    end
  end

  oled_spi_shifter u_shifter (
    .clk6p25m (clk6p25m),
    .rst_n    (rst_n),
    .load     (sh_load),
    .len16    (sh_len16),
    .din      (sh_din),
    .sclk     (sh_sclk),
    .sdin     (sh_sdin),
    .done     (sh_done)
  );

  assign io.pixel_index = pixel_index;
  assign io.frame_begin = frame_begin;
  assign io.oled_cs     = cs;
  assign io.oled_dc     = dc;
  assign io.oled_sclk   = sh_sclk;
  assign io.oled_sdin   = sh_sdin;

endmodule

// File: tb/tb_oled_frame_streamer.sv
// tb/tb_oled_frame_streamer.sv - randomized frame/SPI bench with a decoded-byte reference model
`timescale 1ns/1ps
module tb_oled_frame_streamer;

  localparam int NPIX    = 48;
  localparam int GAP     = 64;
  localparam int CS_LOW  = 6 * 16 + NPIX * 32;
  localparam int FRAME_T = CS_LOW + GAP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oled_frame_streamer_if bus ();

  oled_frame_streamer #(
    .PIX_LAT    (16),
    .GAP_CYCLES (GAP),
    .NPIX       (NPIX)
  ) dut (
    .clk6p25m (clk),
    .rst_n    (rst_n),
    .io       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Image source stub: word = {3'b0, index} ^ key, delivered lat cycles after the index
  int          lat = 1;
  logic [15:0] key = 16'h0000;
  logic [12:0] pipe [16];

  function automatic logic [15:0] img(input int p, input logic [15:0] k);
    return {3'b000, 13'(p)} ^ k;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= bus.pixel_index;
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.pixel_data = img(int'(pipe[lat-1]), key);

  // Reference model: expected {dc,byte} stream per frame, SPI decoder and frame timing counters
  logic [7:0] pre [6] = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};
  logic [8:0] exp_q [$];
  logic       rst_seen = 1'b0;
  logic       sclk_q   = 1'b1;
  logic       cs_q     = 1'b1;
  logic [7:0] rx       = 8'h00;
  logic       rx_dc    = 1'b0;
  int nbits = 0, byte_no = 0, mon_p = 0;
  int cs_low_run = 0, cs_high_run = 0, last_high_run = 0;
  int fb_count = 0, pix_words = 0, frames_done = 0;
  logic [15:0] w;

  always @(negedge clk) begin
    if (!rst_seen) begin
      exp_q.delete();
      nbits       = 0;
      byte_no     = 0;
      pix_words   = 0;
      cs_low_run  = 0;
      cs_high_run = 1;
    end else begin
      check("idx_range", 32'(bus.pixel_index <= 13'(NPIX - 1)), 1);
      if (bus.oled_cs) check("sclk_idle", bus.oled_sclk, 1);
      if (bus.frame_begin) begin
        fb_count++;
        last_high_run = cs_high_run;
        cs_high_run   = 0;
        cs_low_run    = 0;
        check("fb_cs", bus.oled_cs, 0);
        check("fb_dc", bus.oled_dc, 0);
        check("fb_q_empty", exp_q.size(), 0);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, pre[i]});
        for (int p = 0; p < NPIX; p++) begin
          w = img(p, key);
          exp_q.push_back({1'b1, w[15:8]});
          exp_q.push_back({1'b1, w[7:0]});
        end
        byte_no   = 0;
        nbits     = 0;
        pix_words = 0;
      end
      if (!bus.oled_cs && !sclk_q && bus.oled_sclk) begin
        if (nbits == 0) rx_dc = bus.oled_dc;
        else check("dc_stable", bus.oled_dc, rx_dc);
        rx = {rx[6:0], bus.oled_sdin};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (exp_q.size() == 0) check("byte_extra", {rx_dc, rx}, 32'h10000);
          else check("byte", {rx_dc, rx}, exp_q.pop_front());
          if (byte_no < 6) begin
            check("idx_cmd", bus.pixel_index, 0);
          end else begin
            mon_p = (byte_no - 6) / 2;
            check("idx_prefetch", bus.pixel_index, (mon_p == NPIX - 1) ? mon_p : mon_p + 1);
            if (((byte_no - 6) % 2) == 1) pix_words++;
          end
          byte_no++;
        end
      end
      if (bus.oled_cs && !cs_q) begin
        frames_done++;
        check("cs_low_len", cs_low_run, CS_LOW);
        check("frame_all_bytes", exp_q.size(), 0);
        check("idx_wrap", bus.pixel_index, 0);
        cs_high_run = 0;
      end
      if (bus.oled_cs) cs_high_run++;
      else cs_low_run++;
    end
    rst_seen = rst_n;
    sclk_q   = bus.oled_sclk;
    cs_q     = bus.oled_cs;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"},   bus.oled_cs, 1);
    check({tag, "_sclk"}, bus.oled_sclk, 1);
    check({tag, "_sdin"}, bus.oled_sdin, 0);
    check({tag, "_dc"},   bus.oled_dc, 0);
    check({tag, "_idx"},  bus.pixel_index, 0);
    check({tag, "_fb"},   bus.frame_begin, 0);
  endtask

  task automatic wait_fb(input int target, input int limit, input string tag);
    int i = 0;
    while (fb_count < target && i < limit) begin step(); i++; end
    check(tag, 32'(fb_count >= target), 1);
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    int i = 0;
    while (frames_done < target && i < limit) begin step(); i++; end
    check(tag, 32'(frames_done >= target), 1);
  endtask

  task automatic wait_pix(input int target, input int limit, input string tag);
    int i = 0;
    while (pix_words < target && i < limit) begin step(); i++; end
    check(tag, 32'(pix_words >= target), 1);
  endtask

  int fb0, k;

  initial begin
    bus.en = 1'b0;
    key    = 16'($urandom);

    repeat (4) step();
    check_reset_vals("rst");

    bus.en = 1'b1;
    rst_n  = 1'b1;
    wait_fb(1, GAP + 10, "fb_first_timeout");
    check("gap_after_reset", last_high_run, GAP);

    wait_pix($urandom_range(5, NPIX - 8), FRAME_T, "drop_point_timeout");
    bus.en = 1'b0;
    wait_done(1, FRAME_T, "frame1_timeout");
    check("end_cs", bus.oled_cs, 1);
    check("end_idx", bus.pixel_index, 0);
    fb0 = fb_count;
    repeat (3 * GAP) step();
    check("no_restart", fb_count, fb0);
    check("idle_cs", bus.oled_cs, 1);

    key    = 16'($urandom);
    bus.en = 1'b1;
    wait_fb(2, 10, "fb_from_idle_timeout");
    wait_pix($urandom_range(2, NPIX - 3), FRAME_T, "reset_point_timeout");
    repeat ($urandom_range(0, 31)) step();
    rst_n = 1'b0;
    step();
    check_reset_vals("midrst");
    rst_n = 1'b1;
    wait_fb(3, GAP + 10, "fb_after_midrst_timeout");
    check("gap_after_midrst", last_high_run, GAP);

    for (int f = 0; f < 5; f++) begin
      k = frames_done + 1;
      wait_done(k, FRAME_T + 20, "loop_frame_timeout");
      if (f == 2) lat = 16;
      key = 16'($urandom);
      for (int i = 0; i < 40; i++) begin
        bus.en = 1'($urandom_range(0, 1));
        step();
      end
      bus.en = (f < 4);
      if (f < 4) begin
        wait_fb(fb_count + 1, GAP, "loop_fb_timeout");
        check("gap_between_frames", last_high_run, GAP);
      end
    end

    fb0 = fb_count;
    repeat (2 * GAP) step();
    check("final_no_restart", fb_count, fb0);
    check("final_cs", bus.oled_cs, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
